serial_shifter: RTL and testbench
=================================

# serial_shifter

Multi-cycle shift unit for the ALU. It performs RISC-V SRL/SRLI, SLL/SLLI and SRA/SRAI by shifting one bit position per clock, using a start/busy/done handshake. Only the low log2(OPD_LENGTH) bits of the shift amount are used. It is the area-saving alternative to the single-cycle barrel shifter and is driven by the ALU/issue control path, which waits on `done` before writing back.

## Interface
- `OPD_LENGTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default 5: shift-amount width; must equal log2(`OPD_LENGTH`).
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request; sampled only in IDLE.
- `opd1`, input, `OPD_LENGTH`: value to shift; captured on accepted `start`.
- `opd2`, input, `OPD_LENGTH`: shift amount; only bits [`SHAMT_WIDTH`-1:0] are captured, upper bits are ignored.
- `alu_op_select`, input, 3: 001 = SRL, 011 = SLL, 111 = SRA; captured on accepted `start`.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse; `shifter_result` is valid in that cycle.
- `shifter_result`, output, `OPD_LENGTH`: registered result; holds until the next accepted `start`.
- `illegal_op`, output, 1: valid with `done`; high if the captured select was not a shift code.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE, `start`=1:**
  - Load `shifter_result` ← `opd1`, count ← shamt, op ← `alu_op_select`.
  - If the select is illegal: load `shifter_result` ← 0, set `illegal_op`, go to DONE.
  - Else if shamt = 0: go to DONE with `illegal_op` = 0.
  - Else: go to SHIFT with `illegal_op` = 0.
- **IDLE, `start`=0:** stay in IDLE; all registers hold.
- **SHIFT:** each cycle applies one shift step and decrements count. When count = 1, the next state is DONE.
  - SRL: right shift by 1, MSB ← 0.
  - SLL: left shift by 1, LSB ← 0.
  - SRA: right shift by 1, MSB ← old MSB (sign extension).
- **DONE:** `done` = 1 for exactly this cycle, then go to IDLE unconditionally.
- `start` asserted while `busy` = 1, including in the DONE cycle, is ignored. It is neither queued nor does it corrupt the in-flight operation.
- `illegal_op` and `shifter_result` hold their values from DONE through IDLE until the next accepted `start`.
- **Reset, asserted at any time (including mid-SHIFT):**
  - Immediately forces state IDLE and count 0.
  - Outputs go to `busy` = 0, `done` = 0, `shifter_result` = 0, `illegal_op` = 0.
  - The in-flight operation is discarded and no `done` is produced for it.
- Arithmetic: all steps stay within `OPD_LENGTH` bits. The count register is `SHAMT_WIDTH` bits, so the maximum shamt is `OPD_LENGTH`-1, with no wrap.

## Timing
- Let E0 be the rising edge at which `start` is sampled in IDLE.
- `done` is high during the cycle after edge E(shamt). The latency from E0 to the `done` cycle is shamt+1 cycles:
  - shamt = 0 or illegal op: `done` in the cycle right after E0.
  - shamt = 31: `done` 32 cycles after E0.
- `busy` rises in the cycle after E0 and falls in the cycle after the DONE cycle.
- Back-to-back: the earliest next accepted `start` is at the edge ending the first IDLE cycle after DONE. The minimum issue interval is shamt+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- SRL of 0x80000000 with `opd2` = 4 → `shifter_result` = 0x08000000, `done` 5 cycles after E0, `illegal_op` = 0.
- SRA of 0x80000000 with `opd2` = 4 → 0xF8000000. SRA of 0x7FFFFFFF with `opd2` = 31 → 0x00000000, `done` at cycle 32.
- SLL of 0x00000001 with `opd2` = 0x00000020 (shamt = 0, upper bits ignored) → 0x00000001, `done` the cycle after E0. Then SLL by 31 → 0x80000000.
- `alu_op_select` = 010 with `opd1` = 0xFFFFFFFF → `done` the cycle after E0, `shifter_result` = 0, `illegal_op` = 1.
- Hold `start` high throughout an SRL by 8 with `opd1` changing every cycle → exactly one result, equal to the E0 operand >> 8. The next op is accepted only after the IDLE cycle.
- Assert `rst` asynchronously mid-SHIFT, between clock edges → `busy`, `done`, `shifter_result` and `illegal_op` are 0 immediately. No `done` pulse follows. A fresh request after `rst` is released completes correctly.

Source files
------------

// File: rtl/serial_shifter.sv
// Bit-serial SRL/SLL/SRA unit: one bit position per clock under a start/busy/done handshake.
// Latency: done arrives shamt+1 cycles after start is accepted (1 cycle for shamt=0 or an illegal op).
// Backpressure: start is only sampled while idle; requests made while busy are dropped, not queued.
module serial_shifter #(
    parameter int OPD_LENGTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [2:0]            alu_op_select,
    output logic                  busy,
    output logic                  done,
    output logic [OPD_LENGTH-1:0] shifter_result,
    output logic                  illegal_op
);

    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SHAMT_WIDTH-1:0]  count_q, count_d;
    logic [2:0]              op_q, op_d;
    logic [OPD_LENGTH-1:0]   result_q, result_d;
    logic                    illegal_q, illegal_d;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic                    sel_legal;

    // Shift amounts wrap modulo the operand width, so the upper opd2 bits never matter.
    logic opd2_unused;
    assign opd2_unused = ^opd2[OPD_LENGTH-1:SHAMT_WIDTH];

    assign shamt     = opd2[SHAMT_WIDTH-1:0];
    assign sel_legal = (alu_op_select == OP_SRL) || (alu_op_select == OP_SLL) ||
                       (alu_op_select == OP_SRA);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = shamt;
                    op_d    = alu_op_select;
                    if (!sel_legal) begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        result_d  = opd1;
                        illegal_d = 1'b0;
                        state_d   = (shamt == '0) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                case (op_q)
                    OP_SRL:  result_d = {1'b0, result_q[OPD_LENGTH-1:1]};
                    OP_SLL:  result_d = {result_q[OPD_LENGTH-2:0], 1'b0};
                    OP_SRA:  result_d = {result_q[OPD_LENGTH-1], result_q[OPD_LENGTH-1:1]};
                    default: result_d = result_q;
                endcase
                count_d = count_q - SHAMT_WIDTH'(1);
                if (count_q == SHAMT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Status outputs decode straight from the state flops, so no input reaches them combinationally.
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign shifter_result = result_q;
    assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: result values, done latency, handshake, illegal ops and async reset.
module tb_serial_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] opd1;
    logic [31:0] opd2;
    logic [2:0]  alu_op_select;
    logic        busy;
    logic        done;
    logic [31:0] shifter_result;
    logic        illegal_op;

    int checks;
    int errors;

    serial_shifter #(.OPD_LENGTH(32), .SHAMT_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .opd1           (opd1),
        .opd2           (opd2),
        .alu_op_select  (alu_op_select),
        .busy           (busy),
        .done           (done),
        .shifter_result (shifter_result),
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from an idle cycle and returns once the unit is idle again.
    // lat counts rising edges after E0 until done is seen; 64 means it never came.
    task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic ill,
                         output logic busy_after_e0);
        start         = 1'b1;
        alu_op_select = sel;
        opd1          = a;
        opd2          = b;
        @(posedge clk);
        #1;
        start         = 1'b0;
        opd1          = 32'hDEAD_BEEF;
        opd2          = 32'h0000_001F;
        busy_after_e0 = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = shifter_result;
        ill = illegal_op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (shifter_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", shifter_result); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    endtask

    task automatic test_srl;
        int lat; logic [31:0] res; logic ill; logic b0;
        issue(3'b001, 32'h8000_0000, 32'd4, lat, res, ill, b0);
        checks++; if (res !== 32'h0800_0000) begin errors++; $display("FAIL srl4_result got %h want 08000000", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL srl4_latency got %0d want 4", lat); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL srl4_illegal got %b want 0", ill); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL srl4_busy_rise got %b want 1", b0); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL srl4_idle busy %b done %b want 0 0", busy, done); end
        checks++; if (shifter_result !== 32'h0800_0000) begin errors++; $display("FAIL srl4_hold got %h want 08000000", shifter_result); end
    endtask

    task automatic test_sra;
        int lat; logic [31:0] res; logic ill; logic b0;
        issue(3'b111, 32'h8000_0000, 32'd4, lat, res, ill, b0);
        checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra4_result got %h want f8000000", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL sra4_latency got %0d want 4", lat); end
        issue(3'b111, 32'h7FFF_FFFF, 32'd31, lat, res, ill, b0);
        checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL sra31_result got %h want 00000000", res); end
        checks++; if (lat !== 31) begin errors++; $display("FAIL sra31_latency got %0d want 31", lat); end
    endtask

    task automatic test_sll;
        int lat; logic [31:0] res; logic ill; logic b0;
        issue(3'b011, 32'h0000_0001, 32'h0000_0020, lat, res, ill, b0);
        checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL sll0_result got %h want 00000001", res); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL sll0_latency got %0d want 0", lat); end
        issue(3'b011, 32'h0000_0001, 32'd31, lat, res, ill, b0);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL sll31_result got %h want 80000000", res); end
        checks++; if (lat !== 31) begin errors++; $display("FAIL sll31_latency got %0d want 31", lat); end
        issue(3'b011, 32'h0000_00F3, 32'hFFFF_FFE3, lat, res, ill, b0);
        checks++; if (res !== 32'h0000_0798) begin errors++; $display("FAIL sll3_result got %h want 00000798", res); end
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] res; logic ill; logic b0;
        issue(3'b010, 32'hFFFF_FFFF, 32'd7, lat, res, ill, b0);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL illegal_result got %h want 00000000", res); end
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag got %b want 1", ill); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency got %0d want 0", lat); end
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_hold got %b want 1", illegal_op); end
        issue(3'b001, 32'h0000_00F0, 32'd4, lat, res, ill, b0);
        checks++; if (ill !== 1'b0 || res !== 32'h0000_000F) begin errors++; $display("FAIL after_illegal got ill %b res %h want 0 0000000f", ill, res); end
    endtask

    // start held high the whole time; opd1 changes every cycle (pattern A5000000 ^ c*00010101).
    task automatic test_start_held;
        int dones_first;
        logic [31:0] res_first, res_second;
        logic busy9, busy10, done18;
        dones_first = 0;
        res_first = '0; res_second = '0; busy9 = 1'bx; busy10 = 1'bx; done18 = 1'b0;
        start = 1'b1;
        alu_op_select = 3'b001;
        opd2 = 32'd8;
        for (int c = 0; c <= 18; c++) begin
            opd1 = 32'hA500_0000 ^ (32'(c) * 32'h0001_0101);
            @(posedge clk);
            #1;
            if (c <= 9 && done === 1'b1) begin dones_first++; res_first = shifter_result; end
            if (c == 9) busy9 = busy;
            if (c == 10) begin busy10 = busy; start = 1'b0; end
            if (c == 18) begin done18 = done; res_second = shifter_result; end
        end
        @(posedge clk);
        #1;
        checks++; if (dones_first !== 1) begin errors++; $display("FAIL held_done_count got %0d want 1", dones_first); end
        checks++; if (res_first !== 32'h00A5_0000) begin errors++; $display("FAIL held_result got %h want 00a50000", res_first); end
        checks++; if (busy9 !== 1'b0) begin errors++; $display("FAIL held_idle_gap got busy %b want 0", busy9); end
        checks++; if (busy10 !== 1'b1) begin errors++; $display("FAIL held_reaccept got busy %b want 1", busy10); end
        checks++; if (done18 !== 1'b1 || res_second !== 32'h00A5_0A0A) begin errors++; $display("FAIL held_second got done %b res %h want 1 00a50a0a", done18, res_second); end
    endtask

    task automatic test_async_reset;
        int lat; int stray; logic [31:0] res; logic ill; logic b0;
        stray = 0;
        start = 1'b1; alu_op_select = 3'b111; opd1 = 32'h8000_0000; opd2 = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_status busy %b done %b want 0 0", busy, done); end
        checks++; if (shifter_result !== 32'h0 || illegal_op !== 1'b0) begin errors++; $display("FAIL arst_outputs res %h ill %b want 00000000 0", shifter_result, illegal_op); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL arst_no_done got %0d active cycles want 0", stray); end
        issue(3'b001, 32'h1234_5678, 32'd4, lat, res, ill, b0);
        checks++; if (res !== 32'h0123_4567 || lat !== 4) begin errors++; $display("FAIL arst_fresh got res %h lat %0d want 01234567 4", res, lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        opd1 = '0;
        opd2 = '0;
        alu_op_select = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_srl;
        test_sra;
        test_sll;
        test_illegal;
        test_start_held;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
